// File: rtl/deompressor_pkg.sv
// Shared LZRW1 decompressor definitions: stream constants, the token format
// handed from the parser to the decompressor core, and the parser state set.
package deompressor_pkg;

    localparam int HISTORY_SIZE = 4096;
    localparam int OFFSET_WIDTH = $clog2(HISTORY_SIZE);
    localparam int CTRL_BITS    = 16;
    localparam int MIN_MATCH    = 3;
    localparam int MAX_MATCH    = 16;
    localparam int LENGTH_WIDTH = 5;
    localparam int BITCNT_WIDTH = $clog2(CTRL_BITS);

    // One decoded item: a literal byte, or a back-reference (offset, length).
    typedef struct packed {
        logic                    is_copy;
        logic [7:0]              literal;
        logic [OFFSET_WIDTH-1:0] offset;
        logic [LENGTH_WIDTH-1:0] length;
    } data_in_t;

    localparam int TOK_WIDTH = $bits(data_in_t);

    typedef enum logic [2:0] {
        S_CTRL_LO = 3'd0,
        S_CTRL_HI = 3'd1,
        S_ITEM    = 3'd2,
        S_COPY_LO = 3'd3,
        S_DRAIN   = 3'd4
    } parser_state_e;

    // Literal token: only the byte field carries information.
    function automatic data_in_t make_literal(input logic [7:0] b);
        data_in_t t;
        t         = '0;
        t.literal = b;
        return t;
    endfunction

    // Copy token from the two item bytes: offset = {b0[7:4], b1}, length = b0[3:0] + 1.
    function automatic data_in_t make_copy(input logic [7:0] b0, input logic [7:0] b1);
        data_in_t t;
        t         = '0;
        t.is_copy = 1'b1;
        t.offset  = {b0[7:4], b1};
        t.length  = {1'b0, b0[3:0]} + 5'd1;
        return t;
    endfunction

endpackage

// File: rtl/lzrw1_token_parser.sv
// LZRW1 token parser: splits the compressed byte stream into control words and
// literal/copy tokens, holding one registered token for the decompressor core.
module lzrw1_token_parser
    import deompressor_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [TOK_WIDTH-1:0] tok_out,
    output logic                 tok_valid,
    output logic                 tok_last,
    input  logic                 decompressor_busy,
    output logic                 parser_idle,
    output logic                 format_error
);

    parser_state_e           state_q, state_d;
    logic [CTRL_BITS-1:0]    ctrl_q, ctrl_d;
    logic [BITCNT_WIDTH-1:0] bitcnt_q, bitcnt_d;
    logic [7:0]              byte0_q, byte0_d;
    data_in_t                tok_q, tok_d;
    logic                    tok_valid_q, tok_valid_d;
    logic                    tok_last_q, tok_last_d;
    logic                    format_error_q, format_error_d;

    logic                    accept;
    logic                    emit;
    logic                    item_done;
    data_in_t                new_tok;
    data_in_t                copy_tok;
    logic                    copy_bad;

    // State register: all parser state, synchronously cleared by reset.
    always_ff @(posedge clock) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // pre-edge values; the reset branch is synchronous and clears everything.
        if (!reset) begin
            state_q        <= S_CTRL_LO;
            ctrl_q         <= '0;
            bitcnt_q       <= '0;
            byte0_q        <= '0;
            tok_q          <= '0;
            tok_valid_q    <= 1'b0;
            tok_last_q     <= 1'b0;
            format_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ctrl_q         <= ctrl_d;
            bitcnt_q       <= bitcnt_d;
            byte0_q        <= byte0_d;
            tok_q          <= tok_d;
            tok_valid_q    <= tok_valid_d;
            tok_last_q     <= tok_last_d;
            format_error_q <= format_error_d;
        end
    end

    // Next-state: walk the control word one item at a time and build tokens.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d        = state_q;
        ctrl_d         = ctrl_q;
        bitcnt_d       = bitcnt_q;
        byte0_d        = byte0_q;
        tok_d          = tok_q;
        tok_valid_d    = tok_valid_q;
        tok_last_d     = tok_last_q;
        format_error_d = format_error_q;
        emit           = 1'b0;
        item_done      = 1'b0;
        new_tok        = '0;

        copy_tok = make_copy(byte0_q, in_byte);
        copy_bad = (copy_tok.length < LENGTH_WIDTH'(MIN_MATCH)) || (copy_tok.offset == '0);

        // A transfer frees the slot; a new token loaded this cycle overrides below.
        if (tok_valid_q && !decompressor_busy) begin
            tok_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                S_CTRL_LO: begin
                    if (in_last) begin
                        format_error_d = 1'b1;
                    end else begin
                        ctrl_d[7:0] = in_byte;
                        state_d     = S_CTRL_HI;
                    end
                end
                S_CTRL_HI: begin
                    // An empty control word ending the block is legal.
                    if (in_last) begin
                        state_d = S_CTRL_LO;
                    end else begin
                        ctrl_d[15:8] = in_byte;
                        bitcnt_d     = '0;
                        state_d      = S_ITEM;
                    end
                end
                S_ITEM: begin
                    if (!ctrl_q[bitcnt_q]) begin
                        new_tok   = make_literal(in_byte);
                        emit      = 1'b1;
                        item_done = 1'b1;
                    end else if (in_last) begin
                        // Stream ended halfway through a copy item.
                        format_error_d = 1'b1;
                        bitcnt_d       = '0;
                        state_d        = S_CTRL_LO;
                    end else begin
                        byte0_d = in_byte;
                        state_d = S_COPY_LO;
                    end
                end
                S_COPY_LO: begin
                    if (copy_bad) begin
                        format_error_d = 1'b1;
                        bitcnt_d       = '0;
                        state_d        = in_last ? S_CTRL_LO : S_DRAIN;
                    end else begin
                        new_tok   = copy_tok;
                        emit      = 1'b1;
                        item_done = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (in_last) begin
                        state_d = S_CTRL_LO;
                    end
                end
                default: begin
                    state_d = S_CTRL_LO;
                end
            endcase
        end

        // Item bookkeeping: block end or control-word exhaustion fetches a new word.
        if (item_done) begin
            if (in_last) begin
                bitcnt_d = '0;
                state_d  = S_CTRL_LO;
            end else begin
                bitcnt_d = bitcnt_q + 1'b1;
                state_d  = (bitcnt_q == BITCNT_WIDTH'(CTRL_BITS - 1)) ? S_CTRL_LO : S_ITEM;
            end
        end

        if (emit) begin
            tok_d       = new_tok;
            tok_last_d  = in_last;
            tok_valid_d = 1'b1;
        end
    end

    // Outputs: ready passes through the single output slot; idle when nothing pending.
    always_comb begin
        in_ready    = reset && (!tok_valid_q || !decompressor_busy);
        accept      = in_valid && in_ready;
        parser_idle = (state_q == S_CTRL_LO) && !tok_valid_q;
    end

    assign tok_out      = tok_q;
    assign tok_valid    = tok_valid_q;
    assign tok_last     = tok_last_q;
    assign format_error = format_error_q;

endmodule
